memory_cycle: RTL

//  MEM stage of the 5-stage RV32I pipeline. Consumes execute-stage results and

---
 rtl/memory_cycle_if.sv | 38 +++
 rtl/memory_cycle.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/memory_cycle_if.sv
// memory_cycle_if: bundles the MEM-stage inputs and the MEM/WB outputs of memory_cycle.
//   master : pipeline side (drives the M-stage fields, receives the W-stage fields)
//   slave  : memory_cycle side
//   M-stage: RegWriteM, MemWriteM, ResultSrcM, Funct3M, RD_M, ALU_ResultM, WriteDataM,
//            PCPlus4M, StallM, FlushM
//   W-stage: RegWriteW, ResultSrcW, RDW, PCPlus4W, ALU_ResultW, ReadDataW, MisalignW
interface memory_cycle_if;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        ResultSrcM;
    logic [2:0]  Funct3M;
    logic [4:0]  RD_M;
    logic [31:0] ALU_ResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic        StallM;
    logic        FlushM;

    logic        RegWriteW;
    logic        ResultSrcW;
    logic [4:0]  RDW;
    logic [31:0] PCPlus4W;
    logic [31:0] ALU_ResultW;
    logic [31:0] ReadDataW;
    logic        MisalignW;

    modport master (
        output RegWriteM, MemWriteM, ResultSrcM, Funct3M, RD_M, ALU_ResultM, WriteDataM,
               PCPlus4M, StallM, FlushM,
        input  RegWriteW, ResultSrcW, RDW, PCPlus4W, ALU_ResultW, ReadDataW, MisalignW
    );

    modport slave (
        input  RegWriteM, MemWriteM, ResultSrcM, Funct3M, RD_M, ALU_ResultM, WriteDataM,
               PCPlus4M, StallM, FlushM,
        output RegWriteW, ResultSrcW, RDW, PCPlus4W, ALU_ResultW, ReadDataW, MisalignW
    );
endinterface

// File: rtl/memory_cycle.sv
// memory_cycle: MEM stage of the RV32I pipeline. Performs byte/half/word stores into a
// word-organised data memory, synchronous loads with sign/zero extension, misalignment
// trapping, and owns the MEM/WB pipeline register with stall and flush control.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (clears W-stage state, not the memory array)
//   bus  : memory_cycle_if.slave carrying the M-stage inputs and W-stage outputs
module memory_cycle #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    memory_cycle_if.slave bus
);
    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

    logic [31:0]       mem [DEPTH];

    logic [1:0]        off;
    logic [ADDR_W-1:0] idx;
    size_e             size;
    logic              mis;
    logic              store_en;
    logic              ld_en;
    logic [3:0]        be;
    logic [31:0]       wdata;

    logic        regwrite_d, regwrite_q;
    logic        resultsrc_d, resultsrc_q;
    logic [4:0]  rd_d, rd_q;
    logic [31:0] pcplus4_d, pcplus4_q;
    logic [31:0] alu_d, alu_q;
    logic        misalign_d, misalign_q;
    logic [2:0]  funct3_d, funct3_q;
    logic [1:0]  off_d, off_q;
    logic [31:0] rword_q;

    // Address bits above the memory are deliberately ignored (wrap-around).
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.ALU_ResultM[31:ADDR_W+2];

    assign off = bus.ALU_ResultM[1:0];
    assign idx = bus.ALU_ResultM[ADDR_W+1:2];

    // Funct3 011/110/111 fall into the word class.
    always_comb begin
        size = SzWord;
        case (bus.Funct3M[1:0])
            2'b00:   size = SzByte;
            2'b01:   size = SzHalf;
            default: size = SzWord;
        endcase
    end

    assign mis = ((size == SzHalf) && off[0]) || ((size == SzWord) && (off != 2'b00));

    assign store_en = bus.MemWriteM & ~mis & ~bus.StallM & ~bus.FlushM & ~rst;
    // Flush overrides stall, so a flushed slot still loads the data regs.
    assign ld_en    = bus.FlushM | ~bus.StallM;

    // Replicate store data across lanes so each enabled lane just takes its own slice.
    always_comb begin
        be    = 4'b0000;
        wdata = bus.WriteDataM;
        case (size)
            SzByte: begin
                be[off] = 1'b1;
                wdata   = {4{bus.WriteDataM[7:0]}};
            end
            SzHalf: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.WriteDataM[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (store_en && be[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Registered read: a store at edge N is visible to a load sampled at edge N+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            rword_q <= '0;
        end else if (ld_en) begin
            rword_q <= mem[idx];
        end
    end

    always_comb begin
        regwrite_d  = regwrite_q;
        resultsrc_d = resultsrc_q;
        rd_d        = rd_q;
        pcplus4_d   = pcplus4_q;
        alu_d       = alu_q;
        misalign_d  = misalign_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        if (ld_en) begin
            pcplus4_d = bus.PCPlus4M;
            alu_d     = bus.ALU_ResultM;
            funct3_d  = bus.Funct3M;
            off_d     = off;
            if (bus.FlushM) begin
                regwrite_d  = 1'b0;
                resultsrc_d = 1'b0;
                rd_d        = '0;
                misalign_d  = 1'b0;
            end else begin
                regwrite_d  = bus.RegWriteM & ~(mis & bus.ResultSrcM);
                resultsrc_d = bus.ResultSrcM;
                rd_d        = bus.RD_M;
                misalign_d  = mis & (bus.MemWriteM | bus.ResultSrcM);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q  <= 1'b0;
            resultsrc_q <= 1'b0;
            rd_q        <= '0;
            pcplus4_q   <= '0;
            alu_q       <= '0;
            misalign_q  <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
        end else begin
            regwrite_q  <= regwrite_d;
            resultsrc_q <= resultsrc_d;
            rd_q        <= rd_d;
            pcplus4_q   <= pcplus4_d;
            alu_q       <= alu_d;
            misalign_q  <= misalign_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
        end
    end

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] rdata;

    assign sel_byte = rword_q[8*off_q +: 8];
    assign sel_half = off_q[1] ? rword_q[31:16] : rword_q[15:0];

    always_comb begin
        rdata = rword_q;
        case (funct3_q)
            3'b000:  rdata = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  rdata = {{16{sel_half[15]}}, sel_half};
            3'b100:  rdata = {24'b0, sel_byte};
            3'b101:  rdata = {16'b0, sel_half};
            default: rdata = rword_q;
        endcase
    end

    assign bus.RegWriteW   = regwrite_q;
    assign bus.ResultSrcW  = resultsrc_q;
    assign bus.RDW         = rd_q;
    assign bus.PCPlus4W    = pcplus4_q;
    assign bus.ALU_ResultW = alu_q;
    assign bus.MisalignW   = misalign_q;
    assign bus.ReadDataW   = rdata;
endmodule
